uop_queue: RTL and testbench

Parametrised micro-op queue between the decode unit and the execute stage. It absorbs the 0–3 micro-ops the decoder emits per cycle and presents up to OUT_LANES of them in program order to execute, which consumes a variable number per cycle. It generalises the fixed three-slot uop bundle into a buffered, multi-lane, flushable FIFO with configurable width, depth and lane counts.

---
 rtl/uop_pkg.sv | 35 +++
 rtl/uopq_rd_sel.sv | 30 +++
 rtl/uop_queue.sv | 122 ++++++++++++
 tb/tb_uop_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uop_pkg.sv
// Micro-op field layout and shared types for the decode-to-execute queue.
package uop_pkg;

    localparam int UOP_W = 20;

    localparam int ALU_HI     = 19;
    localparam int ALU_LO     = 16;
    localparam int MASK_BIT   = 15;
    localparam int LD_BIT     = 14;
    localparam int WR_BIT     = 13;
    localparam int FLAGS_BIT  = 12;
    localparam int DEST_HI    = 11;
    localparam int DEST_LO    = 8;
    localparam int ALU_MUX_HI = 7;
    localparam int ALU_MUX_LO = 6;
    localparam int B_HI       = 5;
    localparam int B_LO       = 3;
    localparam int A_HI       = 2;
    localparam int A_LO       = 0;

    typedef struct packed {
        logic [3:0] alu;
        logic       mask;
        logic       ld;
        logic       wr;
        logic       flags;
        logic [3:0] dest;
        logic [1:0] alu_mux;
        logic [2:0] b;
        logic [2:0] a;
    } uop_t;

    localparam uop_t UOP_NOP = '0;

endpackage

// File: rtl/uopq_rd_sel.sv
// Head-relative rotating read mux for the uop queue.
// Lanes at or beyond count are forced to zero.
module uopq_rd_sel
    import uop_pkg::*;
#(
    parameter int UOP_W     = 20,
    parameter int DEPTH     = 8,
    parameter int OUT_LANES = 2,
    parameter int PW        = $clog2(DEPTH),
    parameter int CW        = $clog2(OUT_LANES + 1)
) (
    input  logic [UOP_W-1:0]           mem [DEPTH],
    input  logic [PW-1:0]              head,
    input  logic [CW-1:0]              count,
    output logic [OUT_LANES*UOP_W-1:0] uops
);

    logic [PW-1:0] idx;

    always_comb begin
        uops = '0;
        idx  = '0;
        for (int i = 0; i < OUT_LANES; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count)
                uops[i*UOP_W +: UOP_W] = mem[idx];
        end
    end

endmodule

// File: rtl/uop_queue.sv
// Multi-lane, flushable micro-op FIFO between decode and execute.
// Optional same-cycle empty-queue bypass: define UOPQ_BYPASS_EN.
module uop_queue
    import uop_pkg::*;
#(
    parameter int UOP_W     = 20,
    parameter int DEPTH     = 8,
    parameter int IN_LANES  = 3,
    parameter int OUT_LANES = 2
) (
    input  logic                                clk,
    input  logic                                a_rst,
    input  logic                                in_valid,
    input  logic [$clog2(IN_LANES+1)-1:0]       in_count,
    input  logic [IN_LANES*UOP_W-1:0]           in_uops,
    output logic                                in_ready,
    output logic [$clog2(OUT_LANES+1)-1:0]      out_count,
    output logic [OUT_LANES*UOP_W-1:0]          out_uops,
    input  logic [$clog2(OUT_LANES+1)-1:0]      out_take,
    input  logic                                flush,
    output logic [$clog2(DEPTH+1)-1:0]          level,
    output logic                                empty,
    output logic                                full
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CI = $clog2(IN_LANES + 1);
    localparam int CO = $clog2(OUT_LANES + 1);

    logic [UOP_W-1:0]           mem [DEPTH];
    logic [PW-1:0]              head;
    logic [PW-1:0]              tail;
    logic [LW-1:0]              lvl;
    logic                       push_ok;
    logic [CI-1:0]              n_push;
    logic [CO-1:0]              n_take;
    logic [CO-1:0]              rd_count;
    logic [CO-1:0]              skip;
    logic [OUT_LANES*UOP_W-1:0] rd_uops;

    assign level    = lvl;
    assign empty    = (lvl == '0);
    assign full     = (lvl == LW'(DEPTH));
    assign in_ready = (DEPTH - int'(lvl)) >= IN_LANES;

    assign push_ok = in_valid & in_ready & ~flush;
    assign n_push  = !push_ok ? '0 :
                     (int'(in_count) > IN_LANES) ? CI'(IN_LANES) :
                     in_count;

    assign rd_count = (int'(lvl) > OUT_LANES) ? CO'(OUT_LANES) : CO'(lvl);

    uopq_rd_sel #(
        .UOP_W    (UOP_W),
        .DEPTH    (DEPTH),
        .OUT_LANES(OUT_LANES)
    ) u_rd_sel (
        .mem  (mem),
        .head (head),
        .count(rd_count),
        .uops (rd_uops)
    );

`ifdef UOPQ_BYPASS_EN
    localparam int BL = (IN_LANES < OUT_LANES) ? IN_LANES : OUT_LANES;

    logic          bypass;
    logic [CO-1:0] bp_count;

    assign bypass   = empty & push_ok;
    assign bp_count = (int'(n_push) > OUT_LANES) ? CO'(OUT_LANES) : CO'(n_push);

    always_comb begin
        out_count = rd_count;
        out_uops  = rd_uops;
        if (bypass) begin
            out_count = bp_count;
            out_uops  = '0;
            for (int i = 0; i < BL; i++)
                if (CO'(i) < bp_count)
                    out_uops[i*UOP_W +: UOP_W] = in_uops[i*UOP_W +: UOP_W];
        end
    end

    // Lanes consumed straight from the input never land in storage.
    assign skip = bypass ? n_take : '0;
`else
    assign out_count = rd_count;
    assign out_uops  = rd_uops;
    assign skip      = '0;
`endif

    assign n_take = (out_take > out_count) ? out_count : out_take;

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            head <= '0;
            tail <= '0;
            lvl  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            lvl  <= '0;
        end else begin
            head <= head + PW'(n_take);
            tail <= tail + PW'(n_push);
            lvl  <= lvl + LW'(n_push) - LW'(n_take);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_LANES; i++)
            if (i < int'(n_push) && i >= int'(skip))
                mem[tail + PW'(i)] <= in_uops[i*UOP_W +: UOP_W];
    end

    take_le_count: assert property (
        @(posedge clk) disable iff (!a_rst) out_take <= out_count
    );

endmodule

// File: tb/tb_uop_queue.sv
// Self-checking bench for uop_queue against a queue-based reference model.
module tb_uop_queue;
    import uop_pkg::*;

    localparam int W  = 20;
    localparam int D  = 8;
    localparam int IL = 3;
    localparam int OL = 2;

    logic          clk = 1'b0;
    logic          a_rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    in_count = '0;
    logic [IL*W-1:0] in_uops = '0;
    logic          in_ready;
    logic [1:0]    out_count;
    logic [OL*W-1:0] out_uops;
    logic [1:0]    out_take = '0;
    logic          flush = 1'b0;
    logic [3:0]    level;
    logic          empty;
    logic          full;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;
    int unsigned mq[$];

    always #5 clk = ~clk;

    uop_queue #(
        .UOP_W(W), .DEPTH(D), .IN_LANES(IL), .OUT_LANES(OL)
    ) dut (
        .clk      (clk),
        .a_rst    (a_rst),
        .in_valid (in_valid),
        .in_count (in_count),
        .in_uops  (in_uops),
        .in_ready (in_ready),
        .out_count(out_count),
        .out_uops (out_uops),
        .out_take (out_take),
        .flush    (flush),
        .level    (level),
        .empty    (empty),
        .full     (full)
    );

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (D - mq.size()) >= IL;
    endfunction

    function automatic bit m_bypass();
`ifdef UOPQ_BYPASS_EN
        return mq.size() == 0 && in_valid && !flush && m_ready();
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_cnt();
        if (m_bypass())
            return (int'(in_count) < OL) ? int'(in_count) : OL;
        return (mq.size() < OL) ? mq.size() : OL;
    endfunction

    function automatic int m_lane(input int i);
        if (i >= m_cnt()) return 0;
        if (m_bypass()) return int'(in_uops[i*W +: W]);
        return int'(mq[i]);
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            check("level", int'(level), mq.size());
            check("empty", int'(empty), int'(mq.size() == 0));
            check("full", int'(full), int'(mq.size() == D));
            check("in_ready", int'(in_ready), int'(m_ready()));
            check("out_count", int'(out_count), m_cnt());
            for (int i = 0; i < OL; i++)
                check($sformatf("lane%0d", i), int'(out_uops[i*W +: W]), m_lane(i));
        end
    end

    task automatic step(input bit v, input int cnt, input int unsigned base,
                        input int take, input bit fl);
        int t;
        bit acc;
        in_valid = v;
        in_count = 2'(cnt);
        flush    = fl;
        for (int i = 0; i < IL; i++)
            in_uops[i*W +: W] = (i < cnt) ? W'(base + i) : 20'hFFFFF;
        t = (take < m_cnt()) ? take : m_cnt();
        out_take = 2'(t);
        acc = v && m_ready() && !fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (acc)
                for (int i = 0; i < cnt; i++) mq.push_back(base + i);
            repeat (t) void'(mq.pop_front());
        end
        #1;
        in_valid = 1'b0;
        in_count = '0;
        out_take = '0;
        flush    = 1'b0;
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq.size() > 0 && n < 20) begin
            step(0, 0, 0, 2, 0);
            n++;
        end
        check("drain_level", int'(level), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned base;
        #2;
        check("rst_level", int'(level), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_ready", int'(in_ready), 1);
        check("rst_count", int'(out_count), 0);
        check("rst_uops", int'(out_uops != '0), 0);
        #10 a_rst = 1'b1;
        @(posedge clk);
        #1;
        checking = 1'b1;

        step(1, 3, 32'h10001, 0, 0);
        check("t2_level", int'(level), 3);
        check("t2_count", int'(out_count), 2);
        check("t2_lane0", int'(out_uops[19:0]), 'h10001);
        check("t2_lane1", int'(out_uops[39:20]), 'h10002);

        step(1, 3, 32'h10004, 0, 0);
        check("t3_level6", int'(level), 6);
        check("t3_ready0", int'(in_ready), 0);
        step(1, 3, 32'h20000, 0, 0);
        check("t3_ignored", int'(level), 6);
        step(0, 0, 0, 2, 0);
        check("t3_level4", int'(level), 4);
        check("t3_ready1", int'(in_ready), 1);
        check("t3_head", int'(out_uops[19:0]), 'h10003);

        base = 32'h30000;
        repeat (20) begin
            step(1, 3, base, 2, 0);
            base += 3;
        end
        drain();

        step(1, 3, 32'h40000, 0, 0);
        step(1, 3, 32'h40003, 0, 0);
        step(0, 0, 0, 1, 0);
        check("t5_level5", int'(level), 5);
        step(1, 3, 32'h50000, 2, 1);
        check("t5_flush_level", int'(level), 0);
        check("t5_flush_empty", int'(empty), 1);
        step(1, 2, 32'h60000, 0, 0);
        check("t5_new_lane0", int'(out_uops[19:0]), 'h60000);
        check("t5_new_lane1", int'(out_uops[39:20]), 'h60001);
        drain();

        in_valid = 1'b1;
        in_count = 2'd2;
        in_uops  = {20'hFFFFF, 20'h70001, 20'h70000};
`ifdef UOPQ_BYPASS_EN
        out_take = 2'd2;
        #1;
        check("byp_count", int'(out_count), 2);
        check("byp_lane1", int'(out_uops[39:20]), 'h70001);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_count = '0;
        out_take = '0;
        #1;
        check("byp_level", int'(level), 0);
`else
        out_take = 2'd0;
        #1;
        check("nobyp_count0", int'(out_count), 0);
        @(posedge clk);
        mq.push_back(32'h70000);
        mq.push_back(32'h70001);
        #1;
        in_valid = 1'b0;
        in_count = '0;
        #1;
        check("nobyp_count2", int'(out_count), 2);
        check("nobyp_lane0", int'(out_uops[19:0]), 'h70000);
`endif
        drain();

        step(1, 3, 32'h80000, 0, 0);
        #1;
        a_rst = 1'b0;
        mq.delete();
        #1;
        check("arst_level", int'(level), 0);
        check("arst_count", int'(out_count), 0);
        check("arst_uops", int'(out_uops != '0), 0);
        @(negedge clk);
        #1;
        a_rst = 1'b1;
        step(1, 3, 32'h90000, 0, 0);
        check("arst_push_level", int'(level), 3);
        check("arst_push_lane0", int'(out_uops[19:0]), 'h90000);
        drain();

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
